// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote, false-start
// rejection, parity/framing/overrun flags and a one-entry holding register.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 br_clk_16,
  input  logic                 reset,
  input  logic                 UART_RX,
  input  logic                 RX_ACK,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_STATUS,
  output logic                 RX_VALID,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN
);

  localparam int   H   = OVERSAMPLE / 2;
  localparam int   TW  = $clog2(OVERSAMPLE);
  localparam int   BW  = $clog2(DATA_BITS + 1);
  localparam logic ODD = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done;
  logic                   sample_pt, bit_end, bit_val;

  logic [DATA_BITS-1:0]   data_q;
  logic                   status_q, valid_q, perr_out_q, ferr_out_q, ovr_q;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Decisions are taken on the edge that advances the tick to H+1, so the
  // three votes are rx_s at the edges advancing it to H-1, H and H+1.
  assign sample_pt = (tick_q == TW'(H));
  assign bit_end   = (tick_q == TW'(OVERSAMPLE - 1));
  assign bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    state_d  = state_q;
    tick_d   = bit_end ? '0 : tick_q + 1'b1;
    bitcnt_d = bitcnt_q;
    smp_d    = smp_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    done     = 1'b0;
    if (tick_q == TW'(H - 2)) smp_d[0] = rx_s;
    if (tick_q == TW'(H - 1)) smp_d[1] = rx_s;
    case (state_q)
      S_IDLE: begin
        tick_d   = '0;
        bitcnt_d = '0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (sample_pt && bit_val) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sample_pt) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bitcnt_q == BW'(DATA_BITS - 1)) begin
            bitcnt_d = '0;
            state_d  = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (sample_pt) perr_d = (^shift_q) ^ bit_val ^ ODD;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (sample_pt) begin
          ferr_d = ferr_q | ~bit_val;
          if (bitcnt_q == BW'(STOP_BITS - 1)) begin
            done    = 1'b1;
            tick_d  = '0;
            state_d = ((shift_q == '0) && ferr_d) ? S_BRK : S_IDLE;
          end
        end else if (bit_end) begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_BRK: begin
        tick_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge br_clk_16 or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      smp_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], UART_RX};
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      smp_q    <= smp_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge br_clk_16 or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      status_q   <= 1'b0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      status_q <= done;
      if (done) begin
        if (!valid_q || RX_ACK) begin
          data_q     <= shift_q;
          perr_out_q <= perr_d;
          ferr_out_q <= ferr_d;
          valid_q    <= 1'b1;
          if (RX_ACK) ovr_q <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (RX_ACK) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign RX_DATA    = data_q;
  assign RX_STATUS  = status_q;
  assign RX_VALID   = valid_q;
  assign PARITY_ERR = perr_out_q;
  assign FRAME_ERR  = ferr_out_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 receiver and an even-parity
// receiver, each with its own line, ack and expected-result queue.
module tb_uart_rx_param;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       valid, perr, ferr, ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] d0, d1;
  logic       st0, st1, v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u0 (
    .br_clk_16(clk), .reset(rst_n), .UART_RX(rx0), .RX_ACK(ack0),
    .RX_DATA(d0), .RX_STATUS(st0), .RX_VALID(v0), .PARITY_ERR(pe0),
    .FRAME_ERR(fe0), .OVERRUN(ov0)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u1 (
    .br_clk_16(clk), .reset(rst_n), .UART_RX(rx1), .RX_ACK(ack1),
    .RX_DATA(d1), .RX_STATUS(st1), .RX_VALID(v1), .PARITY_ERR(pe1),
    .FRAME_ERR(fe1), .OVERRUN(ov1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives n bits LSB first, one bit per OS cycles; cycle gpos of the frame is inverted.
  task automatic send_bits(input int ln, input logic [15:0] b, input int n, input int gpos);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < OS; j++) begin
        if (ln == 0) rx0 = b[i] ^ ((i * OS + j) == gpos);
        else         rx1 = b[i] ^ ((i * OS + j) == gpos);
        @(negedge clk);
      end
    end
    if (ln == 0) rx0 = 1'b1;
    else         rx1 = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gpos);
    send_bits(0, {7'h7f, 1'b1, d, 1'b0}, 10, gpos);
  endtask

  task automatic push0(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.data = d; e.valid = 1'b1; e.perr = pe; e.ferr = fe; e.ovr = ov;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [7:0] d, input logic pe);
    exp_t e;
    e.data = d; e.valid = 1'b1; e.perr = pe; e.ferr = 1'b0; e.ovr = 1'b0;
    q1.push_back(e);
  endtask

  task automatic ack_chk(input int ln, input logic [7:0] hold);
    if (ln == 0) ack0 = 1'b1; else ack1 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (ln == 0) begin
      check("u0_ack_valid", 32'(v0), 0);
      check("u0_ack_ovr", 32'(ov0), 0);
      check("u0_ack_data_hold", 32'(d0), 32'(hold));
    end else begin
      check("u1_ack_valid", 32'(v1), 0);
      check("u1_ack_data_hold", 32'(d1), 32'(hold));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs;
    check("rst_data", 32'(d0), 0);
    check("rst_status", 32'(st0), 0);
    check("rst_valid", 32'(v0), 0);
    check("rst_perr", 32'(pe0), 0);
    check("rst_ferr", 32'(fe0), 0);
    check("rst_ovr", 32'(ov0), 0);
  endtask

  always begin
    @(negedge clk);
    if (st0 === 1'b1) begin
      check("u0_status_expected", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("u0_data", 32'(d0), 32'(e0.data));
        check("u0_valid", 32'(v0), 32'(e0.valid));
        check("u0_perr", 32'(pe0), 32'(e0.perr));
        check("u0_ferr", 32'(fe0), 32'(e0.ferr));
        check("u0_ovr", 32'(ov0), 32'(e0.ovr));
      end
      @(negedge clk);
      check("u0_status_width", 32'(st0), 0);
    end
  end

  always begin
    @(negedge clk);
    if (st1 === 1'b1) begin
      check("u1_status_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("u1_data", 32'(d1), 32'(e1.data));
        check("u1_valid", 32'(v1), 32'(e1.valid));
        check("u1_perr", 32'(pe1), 32'(e1.perr));
        check("u1_ferr", 32'(fe1), 32'(e1.ferr));
      end
      @(negedge clk);
      check("u1_status_width", 32'(st1), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(4);
    chk_reset_outputs();
    rst_n = 1'b1;
    idle(8);

    // 0xA5, no ack, latency from start edge to RX_STATUS
    push0(8'hA5, 1'b0, 1'b0, 1'b0);
    lat = 0;
    fork
      send_byte(8'hA5, -1);
      begin
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk);
          #1;
          if (st0) begin lat = c; break; end
        end
      end
    join
    check("u0_latency", 32'(lat), 2 + 9 * OS + OS / 2 + 2);
    idle(32);
    ack_chk(0, 8'hA5);

    // false start, then a good frame
    rx0 = 1'b0;
    idle(4);
    rx0 = 1'b1;
    idle(48);
    push0(8'h3C, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, -1);
    idle(32);
    ack_chk(0, 8'h3C);

    // stop bit low
    push0(8'h55, 1'b0, 1'b1, 1'b0);
    send_bits(0, {7'h00, 1'b0, 8'h55, 1'b0}, 10, -1);
    idle(48);
    ack_chk(0, 8'h55);

    // 20-bit-time break: one frame only
    push0(8'h00, 1'b0, 1'b1, 1'b0);
    rx0 = 1'b0;
    idle(20 * OS);
    rx0 = 1'b1;
    idle(48);
    ack_chk(0, 8'h00);

    // overrun, then ack in the completion cycle
    push0(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, -1);
    push0(8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, -1);
    idle(16);
    ack_chk(0, 8'h11);
    push0(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, -1);
    push0(8'h22, 1'b0, 1'b0, 1'b0);
    fork
      send_byte(8'h22, -1);
      begin
        repeat (2 + 9 * OS + OS / 2 + 2 - 1) @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
      end
    join
    idle(16);
    ack_chk(0, 8'h22);

    // one-cycle glitch at the centre of data bit 3 of 0xFF
    push0(8'hFF, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 4 * OS + OS / 2);
    idle(32);

    // reset mid-frame, then 0x81
    rx0 = 1'b0;
    idle(40);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rx0 = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    push0(8'h81, 1'b0, 1'b0, 1'b0);
    send_byte(8'h81, -1);
    idle(32);

    // even parity: 0x37 has five ones, so the correct parity bit is 1
    push1(8'h37, 1'b1);
    send_bits(1, {5'h1f, 1'b1, 1'b0, 8'h37, 1'b0}, 11, -1);
    idle(32);
    ack_chk(1, 8'h37);
    push1(8'h37, 1'b0);
    lat = 0;
    fork
      send_bits(1, {5'h1f, 1'b1, 1'b1, 8'h37, 1'b0}, 11, -1);
      begin
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk);
          #1;
          if (st1) begin lat = c; break; end
        end
      end
    join
    check("u1_latency", 32'(lat), 2 + 10 * OS + OS / 2 + 2);
    idle(32);

    check("u0_queue_drained", 32'(q0.size()), 0);
    check("u1_queue_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
